// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: burst arbiter for the mlaccel main memory (64K x 16-bit).
// Two requesters (host DMA, compute sequencer) share one memory port. Whole
// bursts are granted non-preemptively. One beat is issued per cycle. Read data
// returns through an RD_LAT-deep (valid, owner) tag pipeline.
// Optional build macro: MLACCEL_MEMARB_HOSTPRIO_EN. When it is defined, the
// host wins every tie. Otherwise ties alternate round-robin on the last owner.
module mlaccel_memarb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [7:0]        h_len,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_wready,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  output logic              h_done,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [7:0]        c_len,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_wready,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  output logic              c_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // A length field of 0 encodes a full 256-beat burst.
  function automatic logic [8:0] len_beats(input logic [7:0] len);
    len_beats = (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

  state_t              r_state;
  logic [1:0]          r_owner;     // 01 host, 10 compute, 00 idle
  logic                r_last_c;    // last completed burst belonged to compute
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [8:0]          r_left;      // beats still to issue in this burst
  logic [RD_LAT-1:0]   r_rtag_vld_p;
  logic [RD_LAT-1:0]   r_rtag_own_p; // 1 = read beat belongs to compute

  logic                w_pick_c;
  logic                w_burst;
  logic                w_beat_rd;
  logic                w_top_vld;
  logic                w_top_own;
  logic [RD_LAT-1:0]   w_rd_rest;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_len;
  logic                w_we;

`ifdef MLACCEL_MEMARB_HOSTPRIO_EN
  assign w_pick_c = c_req & ~h_req;
`else
  assign w_pick_c = c_req & (~h_req | ~r_last_c);
`endif

  assign w_addr    = w_pick_c ? c_addr : h_addr;
  assign w_len     = w_pick_c ? c_len  : h_len;
  assign w_we      = w_pick_c ? c_we   : h_we;

  assign w_burst   = (r_state == S_BURST);
  assign w_beat_rd = w_burst & ~r_we;
  assign w_top_vld = r_rtag_vld_p[RD_LAT-1];
  assign w_top_own = r_rtag_own_p[RD_LAT-1];
  // Tags still in flight behind the one that is emerging this cycle.
  assign w_rd_rest = r_rtag_vld_p << 1;

  // Control FSM: grant, run the burst, drain reads, pulse done.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_owner  <= 2'b00;
      r_last_c <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (h_req | c_req) begin
            r_state <= S_BURST;
            r_owner <= w_pick_c ? 2'b10 : 2'b01;
          end
        end
        S_BURST: begin
          if (r_left == 9'd1) r_state <= r_we ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (w_top_vld && !(|w_rd_rest)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_last_c <= r_owner[1];
          r_owner  <= 2'b00;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Burst address, length and direction latched at grant, stepped per beat.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE) begin
      r_addr <= w_addr;
      r_left <= len_beats(w_len);
      r_we   <= w_we;
    end else if (w_burst) begin
      r_addr <= r_addr + ADDR_ONE;
      r_left <= r_left - 9'd1;
    end
  end

  // Read tag pipeline: each issued read beat emerges RD_LAT cycles later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rtag_vld_p <= '0;
      r_rtag_own_p <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_rtag_vld_p[i] <= r_rtag_vld_p[i-1];
        r_rtag_own_p[i] <= r_rtag_own_p[i-1];
      end
      r_rtag_vld_p[0] <= w_beat_rd;
      r_rtag_own_p[0] <= r_owner[1];
    end
  end

  assign mem_en    = w_burst;
  assign mem_we    = w_burst & r_we;
  assign mem_addr  = w_burst ? r_addr : '0;
  assign mem_wdata = (w_burst & r_we) ? (r_owner[1] ? c_wdata : h_wdata) : '0;

  assign h_wready  = w_burst & r_we & r_owner[0];
  assign c_wready  = w_burst & r_we & r_owner[1];
  assign h_rvalid  = w_top_vld & ~w_top_own;
  assign c_rvalid  = w_top_vld & w_top_own;
  assign h_rdata   = h_rvalid ? mem_rdata : '0;
  assign c_rdata   = c_rvalid ? mem_rdata : '0;
  assign h_done    = (r_state == S_DONE) & r_owner[0];
  assign c_done    = (r_state == S_DONE) & r_owner[1];
  assign owner     = r_owner;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Bench for mlaccel_memarb: directed steps followed by randomized bursts.
// Expected behaviour comes from a shadow memory image and from the burst
// timing rules, evaluated per cycle with plain arithmetic.
`timescale 1ns/1ps
module tb_mlaccel_memarb;
  localparam int RD_LAT = 2;

  logic        clock = 1'b0;
  logic        resetn;
  logic        h_req, h_we, c_req, c_we;
  logic [15:0] h_addr, c_addr, h_wdata, c_wdata;
  logic [7:0]  h_len, c_len;
  logic        h_wready, h_rvalid, h_done, c_wready, c_rvalid, c_done;
  logic [15:0] h_rdata, c_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] bfm_mem [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] rd_pipe [RD_LAT];
  logic        preloaded = 1'b0;

  bit          last_c;
  bit          fixed_wd;
  bit          d_we [2];
  logic [15:0] d_addr [2];
  logic [7:0]  d_len [2];

  always #5 clock = ~clock;

  mlaccel_memarb #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .resetn(resetn),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_len(h_len), .h_wdata(h_wdata),
    .h_wready(h_wready), .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_done(h_done),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_len(c_len), .c_wdata(c_wdata),
    .c_wready(c_wready), .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_done(c_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  function automatic logic [15:0] pat(input int a);
    return 16'((a * 7) + 13) ^ 16'hA5A5;
  endfunction

  // Memory model: RD_LAT-cycle read latency, preloaded with pat() on first edge.
  always @(posedge clock) begin
    if (!preloaded) begin
      for (int i = 0; i < 65536; i++) bfm_mem[i] <= pat(i);
      preloaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      bfm_mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? bfm_mem[mem_addr] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic get_wready(input int p);
    return (p != 0) ? c_wready : h_wready;
  endfunction
  function automatic logic get_rvalid(input int p);
    return (p != 0) ? c_rvalid : h_rvalid;
  endfunction
  function automatic logic get_done(input int p);
    return (p != 0) ? c_done : h_done;
  endfunction
  function automatic logic [15:0] get_rdata(input int p);
    return (p != 0) ? c_rdata : h_rdata;
  endfunction

  function automatic logic [73:0] all_outs();
    return {h_wready, h_rdata, h_rvalid, h_done, c_wready, c_rdata, c_rvalid, c_done,
            mem_en, mem_we, mem_addr, mem_wdata, owner};
  endfunction

  task automatic setreq(input int p, input bit we, input logic [15:0] a, input logic [7:0] l);
    d_we[p] = we; d_addr[p] = a; d_len[p] = l;
    if (p == 0) begin h_req = 1'b1; h_we = we; h_addr = a; h_len = l; end
    else        begin c_req = 1'b1; c_we = we; c_addr = a; c_len = l; end
  endtask

  task automatic dropreq(input int p);
    if (p == 0) h_req = 1'b0; else c_req = 1'b0;
  endtask

  // Winner of the next grant from the current request lines.
  function automatic int pick();
    if (h_req && !c_req) return 0;
    if (c_req && !h_req) return 1;
`ifdef MLACCEL_MEMARB_HOSTPRIO_EN
    return 0;
`else
    return last_c ? 0 : 1;
`endif
  endfunction

  // Called just after an edge while idle with requests driven; follows the
  // whole burst of `who` through its done cycle.
  task automatic serve(input int who);
    int n, total, oth;
    bit we, beat, rv;
    logic [15:0] a0, ea, ra, wd, od;
    logic [1:0] own_exp;
    n = (d_len[who] == 8'd0) ? 256 : int'(d_len[who]);
    we = d_we[who];
    a0 = d_addr[who];
    total = n + (we ? 0 : RD_LAT) + 1;
    oth = 1 - who;
    own_exp = (who != 0) ? 2'b10 : 2'b01;
    @(negedge clock);
    chk("idle_owner", owner, 2'b00);
    chk("idle_mem_en", mem_en, 1'b0);
    for (int j = 1; j <= total; j++) begin
      step();
      wd = fixed_wd ? 16'(j) : 16'($urandom);
      od = 16'($urandom);
      if (who != 0) begin c_wdata = wd; h_wdata = od; end
      else          begin h_wdata = wd; c_wdata = od; end
      @(negedge clock);
      beat = (j <= n);
      chk("mem_en", mem_en, beat);
      if (beat) begin
        ea = a0 + 16'(j - 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, ea);
        if (we) begin
          chk("mem_wdata", mem_wdata, wd);
          ref_mem[ea] = wd;
        end
      end
      chk("wready", get_wready(who), we && beat);
      rv = !we && (j > RD_LAT) && (j <= n + RD_LAT);
      chk("rvalid", get_rvalid(who), rv);
      if (rv) begin
        ra = a0 + 16'(j - RD_LAT - 1);
        chk("rdata", get_rdata(who), ref_mem[ra]);
      end
      chk("done", get_done(who), j == total);
      chk("owner", owner, own_exp);
      chk("loser_quiet", {get_wready(oth), get_rvalid(oth), get_done(oth), get_rdata(oth)}, 0);
    end
    last_c = (who != 0);
  endtask

  initial begin
    int w, mode;
    resetn = 1'b0;
    h_req = 0; h_we = 0; h_addr = 0; h_len = 0; h_wdata = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_len = 0; c_wdata = 0;
    fixed_wd = 0;
    last_c = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", all_outs(), 0);
    step();
    resetn = 1'b1;

    // Host write 1,2,3,4 at 0x0100, then read it back.
    setreq(0, 1'b1, 16'h0100, 8'd4);
    fixed_wd = 1;
    serve(pick());
    fixed_wd = 0;
    step(); dropreq(0);
    setreq(0, 1'b0, 16'h0100, 8'd4);
    serve(pick());
    step(); dropreq(0);

    // Compute write and read across the top of the address space.
    setreq(1, 1'b1, 16'hFFFE, 8'd4);
    serve(pick());
    step(); dropreq(1);
    setreq(1, 1'b0, 16'hFFFE, 8'd4);
    serve(pick());
    step(); dropreq(1);

    // Continuous contention from both ports for four grants.
    setreq(0, 1'b1, 16'h0400, 8'd3);
    setreq(1, 1'b0, 16'h0100, 8'd5);
    for (int r = 0; r < 4; r++) begin
      w = pick();
      serve(w);
      step();
      setreq(w, 1'(r & 1), 16'($urandom), 8'($urandom_range(1, 6)));
    end
    dropreq(0); dropreq(1);

    // len = 0 write: 256 beats.
    setreq(0, 1'b1, 16'($urandom), 8'd0);
    serve(pick());
    step(); dropreq(0);

    // Reset three beats into an 8-beat host read.
    setreq(0, 1'b0, 16'h0200, 8'd8);
    for (int j = 0; j < 3; j++) begin
      step();
      @(negedge clock);
      chk("abort_beat", {mem_en, owner}, 3'b101);
    end
    step();
    resetn = 1'b0;
    #1;
    chk("abort_outputs", all_outs(), 0);
    dropreq(0);
    repeat (2) step();
    resetn = 1'b1;
    last_c = 1'b1;
    for (int j = 0; j < RD_LAT + 6; j++) begin
      step();
      @(negedge clock);
      chk("post_abort_quiet", {h_rvalid, h_done, c_rvalid, c_done, mem_en, owner}, 0);
    end
    step();
    // Tie right after reset: host first, then compute.
    setreq(0, 1'b0, 16'h0100, 8'd4);
    setreq(1, 1'b1, 16'h3000, 8'd2);
    w = pick();
    serve(w);
    step(); dropreq(w);
    serve(pick());
    step(); dropreq(0); dropreq(1);

    // Randomized bursts: single requesters and simultaneous requests.
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 2);
      if (mode != 1) setreq(0, 1'($urandom), 16'($urandom), 8'($urandom_range(1, 12)));
      if (mode != 0) setreq(1, 1'($urandom), 16'($urandom), 8'($urandom_range(1, 12)));
      w = pick();
      serve(w);
      step(); dropreq(w);
      if (mode == 2) begin
        serve(1 - w);
        step(); dropreq(1 - w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
